// File: rtl/crc8_stream_ctrl.sv
// Byte-serial CRC-8 engine: valid/ready byte input, one ROM lookup per byte, valid/ready result.
// crc_table is the registered lookup ROM used by crc8_stream_ctrl.

module crc_table #(
    parameter logic [7:0] POLYNOMIAL = 8'h07
) (
    input  logic       clk_i,
    input  logic       en_i,
    input  logic [7:0] addr_i,
    output logic [7:0] value_o
);

    function automatic logic [7:0] table_entry(input logic [7:0] addr);
        logic [7:0] c;
        c = addr;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ POLYNOMIAL) : (c << 1);
        end
        return c;
    endfunction

    // Sampled only on an accept edge; held through the following wait cycle.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            value_o <= table_entry(addr_i);
        end
    end

endmodule

module crc8_stream_ctrl #(
    parameter logic [7:0] POLYNOMIAL = 8'h07,
    parameter logic [7:0] INIT       = 8'h00,
    parameter logic [7:0] XOR_OUT    = 8'h00,
    parameter logic [7:0] RESIDUE    = 8'h00
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [7:0]  s_data_i,
    input  logic        s_last_i,
    output logic        crc_valid_o,
    input  logic        crc_ready_i,
    output logic [7:0]  crc_o,
    output logic        crc_ok_o,
    output logic [15:0] byte_count_o
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_t;

    state_t      state_q, state_d;
    logic [7:0]  crc_q, crc_d;
    logic        last_q, last_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  rom_value;
    logic        accept;

    assign accept = s_valid_i & s_ready_o & ~clear_i;

    crc_table #(
        .POLYNOMIAL(POLYNOMIAL)
    ) u_rom (
        .clk_i  (clk_i),
        .en_i   (accept),
        .addr_i (crc_q ^ s_data_i),
        .value_o(rom_value)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            crc_q   <= INIT;
            last_q  <= 1'b0;
            count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        last_d  = last_q;
        count_d = count_q;
        if (clear_i) begin
            state_d = StIdle;
            crc_d   = INIT;
            last_d  = 1'b0;
            count_d = 16'h0000;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (s_valid_i) begin
                        last_d  = s_last_i;
                        count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                        state_d = StWait;
                    end
                end
                StWait: begin
                    crc_d   = rom_value;
                    state_d = last_q ? StDone : StIdle;
                end
                StDone: begin
                    if (crc_ready_i) begin
                        crc_d   = INIT;
                        count_d = 16'h0000;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign s_ready_o    = (state_q == StIdle);
    assign crc_valid_o  = (state_q == StDone);
    assign crc_o        = crc_q ^ XOR_OUT;
    assign crc_ok_o     = (crc_q == RESIDUE);
    assign byte_count_o = count_q;

endmodule

// File: tb/tb_crc8_stream_ctrl.sv
// Directed bench for crc8_stream_ctrl: known CRC-8 vectors, stalls, clear/reset aborts and
// random frames checked against a bitwise CRC-8 model.

module tb_crc8_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        s_last = 1'b0;
    logic        crc_valid;
    logic        crc_ready = 1'b0;
    logic [7:0]  crc;
    logic        crc_ok;
    logic [15:0] byte_count;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int first_cyc = 0;
    int valid_cyc = 0;
    logic [7:0] frame[$];

    crc8_stream_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready),
        .s_data_i    (s_data),
        .s_last_i    (s_last),
        .crc_valid_o (crc_valid),
        .crc_ready_i (crc_ready),
        .crc_o       (crc),
        .crc_ok_o    (crc_ok),
        .byte_count_o(byte_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_crc(input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            c = c ^ frame[i];
            for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
        int guard;
        if (gap > 0) begin
            s_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        guard   = 0;
        while (!s_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard == 100) check("ready_timeout", 16'(s_ready), 16'h1);
        @(posedge clk);
        @(negedge clk);
        check("ready_low_in_wait", 16'(s_ready), 16'h0);
    endtask

    task automatic send_frame(input int n, input logic rand_gaps);
        for (int i = 0; i < n; i++) begin
            send_byte(frame[i], i == n - 1, rand_gaps ? int'($urandom_range(0, 3)) : 0);
            if (i == 0) first_cyc = cyc;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic get_result(input logic [7:0] exp_crc, input logic exp_ok,
                              input logic [15:0] exp_cnt, input int hold);
        int guard;
        guard = 0;
        while (!crc_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        valid_cyc = cyc;
        check("result_timeout", 16'(crc_valid), 16'h1);
        check("crc", 16'(crc), 16'(exp_crc));
        check("crc_ok", 16'(crc_ok), 16'(exp_ok));
        check("byte_count", byte_count, exp_cnt);
        check("ready_low_in_done", 16'(s_ready), 16'h0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (crc_valid !== 1'b1 || crc !== exp_crc || crc_ok !== exp_ok || s_ready !== 1'b0)
                check("stall_stable", {crc_valid, crc_ok, s_ready, 5'b0, crc},
                      {1'b1, exp_ok, 1'b0, 5'b0, exp_crc});
        end
        crc_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        crc_ready = 1'b0;
        check("handoff_valid_low", 16'(crc_valid), 16'h0);
        check("handoff_count_zero", byte_count, 16'h0000);
    endtask

    task automatic load_check_string();
        frame = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("reset_ready", 16'(s_ready), 16'h1);
        check("reset_valid", 16'(crc_valid), 16'h0);
        check("reset_count", byte_count, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Check string with valid held; a consumer sampling on posedge first sees the result
        // on the edge after the one that set crc_valid.
        load_check_string();
        send_frame(9, 1'b0);
        get_result(8'hF4, 1'b0, 16'd9, 0);
        check("latency", 16'(valid_cyc - first_cyc + 1), 16'd18);

        // Single-byte frames
        frame = '{8'h01}; send_frame(1, 1'b0); get_result(8'h07, 1'b0, 16'd1, 0);
        frame = '{8'h00}; send_frame(1, 1'b0); get_result(8'h00, 1'b1, 16'd1, 0);
        frame = '{8'hFF}; send_frame(1, 1'b0); get_result(8'hF3, 1'b0, 16'd1, 0);

        // Residue check with appended CRC
        load_check_string();
        frame.push_back(8'hF4);
        send_frame(10, 1'b0);
        get_result(8'h00, 1'b1, 16'd10, 0);

        // Result stall, then crc_q must be back at INIT
        load_check_string();
        send_frame(9, 1'b0);
        get_result(8'hF4, 1'b0, 16'd9, 5);
        frame = '{8'h01}; send_frame(1, 1'b0); get_result(8'h07, 1'b0, 16'd1, 0);

        // Clear after 4 bytes, then the whole frame
        load_check_string();
        for (int i = 0; i < 4; i++) send_byte(frame[i], 1'b0, 0);
        s_valid = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_count", byte_count, 16'h0000);
        check("clear_ready", 16'(s_ready), 16'h1);
        send_frame(9, 1'b0);
        get_result(8'hF4, 1'b0, 16'd9, 0);

        // Clear coinciding with a handshake discards the byte
        s_valid = 1'b1; s_data = 8'h55; s_last = 1'b1; clear = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; clear = 1'b0;
        check("clear_hs_count", byte_count, 16'h0000);
        check("clear_hs_ready", 16'(s_ready), 16'h1);

        // Clear coinciding with crc_ready in ST_DONE is not a handoff
        frame = '{8'h01}; send_frame(1, 1'b0);
        @(negedge clk);
        check("done_before_clear", 16'(crc_valid), 16'h1);
        crc_ready = 1'b1; clear = 1'b1;
        @(negedge clk);
        crc_ready = 1'b0; clear = 1'b0;
        check("clear_done_valid", 16'(crc_valid), 16'h0);
        check("clear_done_count", byte_count, 16'h0000);
        frame = '{8'hFF}; send_frame(1, 1'b0); get_result(8'hF3, 1'b0, 16'd1, 0);

        // Reset pulsed while in ST_WAIT
        load_check_string();
        for (int i = 0; i < 4; i++) send_byte(frame[i], 1'b0, 0);
        s_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rst_wait_count", byte_count, 16'h0000);
        check("rst_wait_ready", 16'(s_ready), 16'h1);
        check("rst_wait_valid", 16'(crc_valid), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(9, 1'b0);
        get_result(8'hF4, 1'b0, 16'd9, 0);

        // Random frames with source and sink gaps
        for (int f = 0; f < 100; f++) begin
            int n;
            n = int'($urandom_range(1, 64));
            frame.delete();
            for (int i = 0; i < n; i++) frame.push_back(8'($urandom));
            send_frame(n, 1'b1);
            get_result(model_crc(n), model_crc(n) == 8'h00, 16'(n), int'($urandom_range(0, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
